// File: rtl/fight_data_control.sv
`default_nettype none
// ============================================================================
// fight_data_control : turn-based battle engine for the fight scene.
// Optional feature macro: FIGHT_CRIT_EN (double damage when ai counter is 0).
// Rev 1.0
// ============================================================================
module fight_data_control #(
  parameter logic [25:0] AI_DELAY = 26'd50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] scene_state,
  input  logic       key_U,
  input  logic       key_D,
  input  logic       key_L,
  input  logic       key_R,
  input  logic       key_C,
  input  logic [7:0] p1_pokemon_hp,
  input  logic [7:0] p1_pokemon_speed,
  input  logic [7:0] p1_skill_1_damage,
  input  logic [7:0] p1_skill_2_damage,
  input  logic [7:0] p1_skill_3_damage,
  input  logic [7:0] p2_pokemon_hp,
  input  logic [7:0] p2_pokemon_speed,
  input  logic [7:0] p2_skill_1_damage,
  input  logic [7:0] p2_skill_2_damage,
  input  logic [7:0] p2_skill_3_damage,
  output logic [7:0] p1_cur_hp,
  output logic [7:0] p2_cur_hp,
  output logic [1:0] skill_cursor,
  output logic       turn,
  output logic       attack_valid,
  output logic       last_attacker,
  output logic [7:0] last_damage,
  output logic       fight_over,
  output logic [1:0] winner
);

  localparam logic [3:0]  FIGHT_SCENE = 4'b0011;
  localparam logic [25:0] DELAY_LAST  = AI_DELAY - 26'd1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_P1_SELECT = 3'd2,
    S_P1_ATTACK = 3'd3,
    S_P2_WAIT   = 3'd4,
    S_P2_ATTACK = 3'd5,
    S_CHECK     = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  p1_hp_q, p1_hp_d;
  logic [7:0]  p2_hp_q, p2_hp_d;
  logic [7:0]  dmg_q, dmg_d;
  logic [7:0]  last_damage_q, last_damage_d;
  logic [1:0]  cursor_q, cursor_d;
  logic [1:0]  winner_q, winner_d;
  logic [1:0]  ai_q, ai_d;
  logic        turn_q, turn_d;
  logic        attack_valid_q, attack_valid_d;
  logic        last_attacker_q, last_attacker_d;
  logic        fight_over_q, fight_over_d;
  logic [25:0] delay_q, delay_d;

  logic [4:0]  keys;
  logic        in_fight;
  logic [7:0]  p1_skill_raw, p2_skill_raw;
  logic [7:0]  p1_dmg_eff, p2_dmg_eff;
  logic [7:0]  hit_on_p2, hit_on_p1;

  assign keys     = {key_U, key_D, key_L, key_R, key_C};
  assign in_fight = (scene_state == FIGHT_SCENE);

  // p1 uses the highlighted skill; p2 uses skill (ai counter + 1)
  always_comb begin
    case (cursor_q)
      2'd2:    p1_skill_raw = p1_skill_2_damage;
      2'd3:    p1_skill_raw = p1_skill_3_damage;
      default: p1_skill_raw = p1_skill_1_damage;
    endcase
    case (ai_q)
      2'd1:    p2_skill_raw = p2_skill_2_damage;
      2'd2:    p2_skill_raw = p2_skill_3_damage;
      default: p2_skill_raw = p2_skill_1_damage;
    endcase
  end

`ifdef FIGHT_CRIT_EN
  function automatic logic [7:0] sat_double(input logic [7:0] raw);
    return raw[7] ? 8'hFF : {raw[6:0], 1'b0};
  endfunction

  assign p1_dmg_eff = (ai_q == 2'd0) ? sat_double(p1_skill_raw) : p1_skill_raw;
  assign p2_dmg_eff = (ai_q == 2'd0) ? sat_double(p2_skill_raw) : p2_skill_raw;
`else
  assign p1_dmg_eff = p1_skill_raw;
  assign p2_dmg_eff = p2_skill_raw;
`endif

  // Damage actually removed never exceeds the defender's remaining hp
  assign hit_on_p2 = (dmg_q > p2_hp_q) ? p2_hp_q : dmg_q;
  assign hit_on_p1 = (dmg_q > p1_hp_q) ? p1_hp_q : dmg_q;

  always_comb begin
    state_d         = state_q;
    p1_hp_d         = p1_hp_q;
    p2_hp_d         = p2_hp_q;
    dmg_d           = dmg_q;
    last_damage_d   = last_damage_q;
    cursor_d        = cursor_q;
    winner_d        = winner_q;
    turn_d          = turn_q;
    attack_valid_d  = 1'b0;
    last_attacker_d = last_attacker_q;
    delay_d         = '0;
    ai_d            = (ai_q == 2'd2) ? 2'd0 : ai_q + 2'd1;

    if ((state_q != S_IDLE) && !in_fight) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_fight) state_d = S_LOAD;
        end
        S_LOAD: begin
          p1_hp_d  = p1_pokemon_hp;
          p2_hp_d  = p2_pokemon_hp;
          cursor_d = 2'd1;
          winner_d = 2'd0;
          turn_d   = (p2_pokemon_speed > p1_pokemon_speed);
          state_d  = turn_d ? S_P2_WAIT : S_P1_SELECT;
        end
        S_P1_SELECT: begin
          case (keys)
            5'b10000: cursor_d = (cursor_q == 2'd1) ? 2'd1 : cursor_q - 2'd1;
            5'b01000: cursor_d = (cursor_q == 2'd3) ? 2'd3 : cursor_q + 2'd1;
            5'b00001: begin
              dmg_d   = p1_dmg_eff;
              state_d = S_P1_ATTACK;
            end
            default: ;
          endcase
        end
        S_P1_ATTACK: begin
          p2_hp_d         = p2_hp_q - hit_on_p2;
          last_damage_d   = hit_on_p2;
          last_attacker_d = 1'b0;
          attack_valid_d  = 1'b1;
          state_d         = S_CHECK;
        end
        S_P2_WAIT: begin
          if (delay_q == DELAY_LAST) begin
            dmg_d   = p2_dmg_eff;
            state_d = S_P2_ATTACK;
          end else begin
            delay_d = delay_q + 26'd1;
          end
        end
        S_P2_ATTACK: begin
          p1_hp_d         = p1_hp_q - hit_on_p1;
          last_damage_d   = hit_on_p1;
          last_attacker_d = 1'b1;
          attack_valid_d  = 1'b1;
          state_d         = S_CHECK;
        end
        S_CHECK: begin
          if (p2_hp_q == 8'd0) begin
            winner_d = 2'd1;
            state_d  = S_DONE;
          end else if (p1_hp_q == 8'd0) begin
            winner_d = 2'd2;
            state_d  = S_DONE;
          end else begin
            turn_d  = ~turn_q;
            state_d = turn_q ? S_P1_SELECT : S_P2_WAIT;
          end
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end

    fight_over_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      p1_hp_q         <= 8'd0;
      p2_hp_q         <= 8'd0;
      dmg_q           <= 8'd0;
      last_damage_q   <= 8'd0;
      cursor_q        <= 2'd1;
      winner_q        <= 2'd0;
      ai_q            <= 2'd0;
      turn_q          <= 1'b0;
      attack_valid_q  <= 1'b0;
      last_attacker_q <= 1'b0;
      fight_over_q    <= 1'b0;
      delay_q         <= 26'd0;
    end else begin
      state_q         <= state_d;
      p1_hp_q         <= p1_hp_d;
      p2_hp_q         <= p2_hp_d;
      dmg_q           <= dmg_d;
      last_damage_q   <= last_damage_d;
      cursor_q        <= cursor_d;
      winner_q        <= winner_d;
      ai_q            <= ai_d;
      turn_q          <= turn_d;
      attack_valid_q  <= attack_valid_d;
      last_attacker_q <= last_attacker_d;
      fight_over_q    <= fight_over_d;
      delay_q         <= delay_d;
    end
  end

  assign p1_cur_hp     = p1_hp_q;
  assign p2_cur_hp     = p2_hp_q;
  assign skill_cursor  = cursor_q;
  assign turn          = turn_q;
  assign attack_valid  = attack_valid_q;
  assign last_attacker = last_attacker_q;
  assign last_damage   = last_damage_q;
  assign fight_over    = fight_over_q;
  assign winner        = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_fight_data_control.sv
`default_nettype none
// Bench for fight_data_control: directed and randomized fights checked
// against a turn-level reference model (hp, damage, winner, timing).
module tb_fight_data_control;

  localparam int         AI_DELAY = 4;
  localparam logic [3:0] FIGHT    = 4'b0011;
`ifdef FIGHT_CRIT_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] scene_state;
  logic       key_U, key_D, key_L, key_R, key_C;
  logic [7:0] p1_hp, p1_spd, p2_hp, p2_spd;
  logic [7:0] p1_sk [1:3];
  logic [7:0] p2_sk [1:3];
  logic [7:0] p1_cur_hp, p2_cur_hp, last_damage;
  logic [1:0] skill_cursor, winner;
  logic       turn, attack_valid, last_attacker, fight_over;

  int n_vec = 0;
  int n_err = 0;
  int edges = 0;

  int m_p1hp, m_p2hp, m_cursor, m_turn, m_winner;
  bit m_done;

  always #5 clk = ~clk;

  // ai counter in the DUT equals (edges since reset) mod 3
  always @(posedge clk) edges <= reset ? 0 : edges + 1;

  fight_data_control #(.AI_DELAY(26'(AI_DELAY))) dut (
    .clk(clk), .reset(reset), .scene_state(scene_state),
    .key_U(key_U), .key_D(key_D), .key_L(key_L), .key_R(key_R), .key_C(key_C),
    .p1_pokemon_hp(p1_hp), .p1_pokemon_speed(p1_spd),
    .p1_skill_1_damage(p1_sk[1]), .p1_skill_2_damage(p1_sk[2]), .p1_skill_3_damage(p1_sk[3]),
    .p2_pokemon_hp(p2_hp), .p2_pokemon_speed(p2_spd),
    .p2_skill_1_damage(p2_sk[1]), .p2_skill_2_damage(p2_sk[2]), .p2_skill_3_damage(p2_sk[3]),
    .p1_cur_hp(p1_cur_hp), .p2_cur_hp(p2_cur_hp), .skill_cursor(skill_cursor),
    .turn(turn), .attack_valid(attack_valid), .last_attacker(last_attacker),
    .last_damage(last_damage), .fight_over(fight_over), .winner(winner)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_keys(input logic [4:0] p);
    {key_U, key_D, key_L, key_R, key_C} = p;
  endtask

  function automatic int eff_dmg(input int raw, input int ai);
    if (CRIT && ai == 0) return (raw * 2 > 255) ? 255 : raw * 2;
    return raw;
  endfunction

  task automatic rand_stats();
    p1_hp  = 8'($urandom_range(20, 200));
    p2_hp  = 8'($urandom_range(20, 200));
    p1_spd = 8'($urandom_range(0, 255));
    p2_spd = 8'($urandom_range(0, 255));
    for (int i = 1; i <= 3; i++) begin
      p1_sk[i] = 8'($urandom_range(5, 60));
      p2_sk[i] = 8'($urandom_range(5, 60));
    end
  endtask

  task automatic enter_fight();
    scene_state = FIGHT;
    step(); step();
    m_p1hp = p1_hp; m_p2hp = p2_hp; m_cursor = 1;
    m_winner = 0; m_done = 0; m_turn = (p2_spd > p1_spd) ? 1 : 0;
    check("load_p1_hp", p1_cur_hp, m_p1hp);
    check("load_p2_hp", p2_cur_hp, m_p2hp);
    check("load_turn", turn, m_turn);
    check("load_cursor", skill_cursor, 1);
    check("load_winner", winner, 0);
    check("load_over", fight_over, 0);
  endtask

  task automatic leave(input logic [3:0] sc);
    scene_state = sc;
    step();
    check("leave_winner", winner, m_winner);
    check("leave_p1_hp", p1_cur_hp, m_p1hp);
    check("leave_p2_hp", p2_cur_hp, m_p2hp);
    check("leave_av", attack_valid, 0);
  endtask

  task automatic leave_rand();
    logic [3:0] sc;
    sc = 4'($urandom_range(0, 15));
    if (sc == FIGHT) sc = 4'b0100;
    leave(sc);
  endtask

  task automatic press_nav(input logic [4:0] pat);
    set_keys(pat);
    step();
    set_keys(5'b0);
    if (pat == 5'b10000) m_cursor = (m_cursor > 1) ? m_cursor - 1 : 1;
    else if (pat == 5'b01000) m_cursor = (m_cursor < 3) ? m_cursor + 1 : 3;
    check("cursor", skill_cursor, m_cursor);
  endtask

  task automatic resolve();
    if (m_p2hp == 0) begin m_winner = 1; m_done = 1; end
    else if (m_p1hp == 0) begin m_winner = 2; m_done = 1; end
    else m_turn = 1 - m_turn;
    check("turn", turn, m_turn);
    check("fight_over", fight_over, m_done);
    check("winner", winner, m_winner);
  endtask

  task automatic attack_p1();
    int dmg, hit;
    dmg = eff_dmg(p1_sk[m_cursor], edges % 3);
    hit = (dmg > m_p2hp) ? m_p2hp : dmg;
    set_keys(5'b00001);
    step();
    set_keys(5'b0);
    check("p1_av_early", attack_valid, 0);
    step();
    m_p2hp -= hit;
    check("p1_av", attack_valid, 1);
    check("p1_dmg", last_damage, hit);
    check("p1_attacker", last_attacker, 0);
    check("p2_hp", p2_cur_hp, m_p2hp);
    step();
    check("p1_av_drop", attack_valid, 0);
    resolve();
  endtask

  task automatic p1_turn();
    logic [4:0] pat;
    int n;
    n = $urandom_range(0, 4);
    for (int i = 0; i < n; i++) begin
      pat = 5'($urandom_range(0, 31));
      if (pat == 5'b00001) pat = 5'b00000;
      press_nav(pat);
    end
    attack_p1();
  endtask

  // Called just after the edge that entered P2_WAIT
  task automatic p2_turn();
    int ai, dmg, hit;
    for (int i = 0; i < AI_DELAY - 1; i++) begin
      set_keys(5'($urandom));
      step();
      check("p2_wait_av", attack_valid, 0);
    end
    set_keys(5'b0);
    ai  = edges % 3;
    dmg = eff_dmg(p2_sk[ai + 1], ai);
    hit = (dmg > m_p1hp) ? m_p1hp : dmg;
    step();
    check("p2_av_early", attack_valid, 0);
    step();
    m_p1hp -= hit;
    check("p2_av", attack_valid, 1);
    check("p2_dmg", last_damage, hit);
    check("p2_attacker", last_attacker, 1);
    check("p1_hp", p1_cur_hp, m_p1hp);
    check("p2_keys_ignored", skill_cursor, m_cursor);
    step();
    check("p2_av_drop", attack_valid, 0);
    resolve();
  endtask

  task automatic play();
    for (int t = 0; t < 1000 && !m_done; t++) begin
      if (m_turn == 0) p1_turn();
      else p2_turn();
    end
    check("fight_end_over", fight_over, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    scene_state = FIGHT;
    set_keys(5'b00001);
    rand_stats();
    repeat (3) step();
    check("rst_p1_hp", p1_cur_hp, 0);
    check("rst_p2_hp", p2_cur_hp, 0);
    check("rst_cursor", skill_cursor, 1);
    check("rst_turn", turn, 0);
    check("rst_av", attack_valid, 0);
    check("rst_attacker", last_attacker, 0);
    check("rst_dmg", last_damage, 0);
    check("rst_over", fight_over, 0);
    check("rst_winner", winner, 0);
    reset = 1'b0;
    set_keys(5'b0);
    scene_state = 4'b0000;
    step(); step();
    check("idle_p1_hp", p1_cur_hp, 0);
    m_winner = 0; m_p1hp = 0; m_p2hp = 0; m_cursor = 1;

    // Turn order
    p1_spd = 8'd244; p2_spd = 8'd194; enter_fight(); leave_rand();
    p1_spd = 8'd194; p2_spd = 8'd244; enter_fight(); leave_rand();
    p1_spd = 8'd100; p2_spd = 8'd100; enter_fight(); leave_rand();

    // Cursor clamping, then p1 attack with skill 3 against 60 hp
    p1_hp = 8'd100; p1_spd = 8'd200; p1_sk[1] = 8'd10; p1_sk[2] = 8'd20; p1_sk[3] = 8'd34;
    p2_hp = 8'd60;  p2_spd = 8'd50;  p2_sk[1] = 8'd7;  p2_sk[2] = 8'd8;  p2_sk[3] = 8'd9;
    enter_fight();
    repeat (3) press_nav(5'b01000);
    repeat (4) press_nav(5'b10000);
    press_nav(5'b11000);
    press_nav(5'b01000);
    press_nav(5'b01000);
    attack_p1();
    p2_turn();
    leave_rand();

    // Saturating hit wins the fight
    p1_hp = 8'd90; p1_spd = 8'd90; p1_sk[1] = 8'd31;
    p2_hp = 8'd20; p2_spd = 8'd10;
    enter_fight();
    attack_p1();
    leave(4'b0100);
    repeat (3) step();
    check("winner_held", winner, 1);

    // Abort during P2_WAIT, then reload and fight to the end
    rand_stats(); p1_spd = 8'd10; p2_spd = 8'd250;
    enter_fight();
    step();
    scene_state = 4'b0000;
    step();
    for (int i = 0; i < AI_DELAY + 2; i++) begin
      step();
      check("abort_av", attack_valid, 0);
    end
    check("abort_p1_hp", p1_cur_hp, m_p1hp);
    rand_stats(); p1_spd = 8'd10; p2_spd = 8'd250;
    enter_fight();
    play();
    leave_rand();

    // Randomized fights
    for (int f = 0; f < 12; f++) begin
      rand_stats();
      enter_fight();
      play();
      leave_rand();
    end

    // Reset in the middle of a fight
    rand_stats();
    enter_fight();
    reset = 1'b1;
    step();
    reset = 1'b0;
    scene_state = 4'b0000;
    check("midrst_p1_hp", p1_cur_hp, 0);
    check("midrst_cursor", skill_cursor, 1);
    check("midrst_turn", turn, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fight_data_control.md
# fight_data_control

Battle engine for the fight scene. Consumes the per-player stats latched by the choose-scene data block (hp, speed, three skill damages per player) and runs a turn-based fight:
- p1 picks skills with the keypad; p2 attacks automatically after a think delay.
- Current hp is tracked per player, and the block declares a winner for the win scene.

Sits between choose-scene data control and the display/scene FSM.

## Interface
Parameters:
- AI_DELAY, 50_000_000 — cycles p2 waits before attacking (0.5 s at 100 MHz); width 26 bits.

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high
- scene_state  in  4  scene code; fight_scene = 4'b0011
- key_U, key_D, key_L, key_R, key_C  in  1 each  one-cycle key pulses, debounced upstream
- p1_pokemon_hp, p1_pokemon_speed  in  8 each  p1 base stats
- p1_skill_1_damage, p1_skill_2_damage, p1_skill_3_damage  in  8 each  p1 skill damages
- p2_pokemon_hp, p2_pokemon_speed  in  8 each  p2 base stats
- p2_skill_1_damage, p2_skill_2_damage, p2_skill_3_damage  in  8 each  p2 skill damages
- p1_cur_hp, p2_cur_hp  out  8  remaining hp
- skill_cursor  out  2  p1 highlighted skill, 1..3
- turn  out  1  0 = p1 to act, 1 = p2 to act
- attack_valid  out  1  one-cycle pulse when damage is applied
- last_attacker  out  1  0 = p1, 1 = p2
- last_damage  out  8  damage actually applied, after saturation
- fight_over  out  1  high while in DONE
- winner  out  2  0 none, 1 p1, 2 p2

## Operation
- Reset values: all outputs 0 except skill_cursor = 1; state IDLE; delay counter 0; ai counter 0.
- The key vector {U,D,L,R,C} acts only when exactly one-hot. Any other pattern is ignored. L and R are unused.
- ai counter: free-running 2-bit count 0,1,2,0,…. It runs in every state.
- States:
  - IDLE: when scene_state == fight_scene, go to LOAD.
  - LOAD: set cur hp from the base hp inputs; skill_cursor = 1; winner = 0; fight_over = 0; turn = (p2_pokemon_speed > p1_pokemon_speed). On a speed tie p1 goes first. Next state is P1_SELECT if turn = 0, else P2_WAIT.
  - P1_SELECT:
    - key_U: cursor − 1, clamped at 1.
    - key_D: cursor + 1, clamped at 3.
    - key_C: go to P1_ATTACK, damage = p1 skill[cursor].
  - P1_ATTACK: p2_cur_hp = max(p2_cur_hp − dmg, 0); pulse attack_valid; last_attacker = 0; last_damage = the hp actually removed, i.e. min(dmg, old hp). Next state CHECK.
  - P2_WAIT: the delay counter counts 0..AI_DELAY−1. At the terminal count, clear the counter, latch skill = ai counter + 1, and go to P2_ATTACK. Keys are ignored in this state.
  - P2_ATTACK: mirror of P1_ATTACK against p1_cur_hp; last_attacker = 1. Next state CHECK.
  - CHECK:
    - p2_cur_hp == 0: winner = 1, go to DONE.
    - Else p1_cur_hp == 0: winner = 2, go to DONE.
    - Else toggle turn and go to P1_SELECT or P2_WAIT.
  - DONE: fight_over = 1; cur hp and winner hold. When scene_state ≠ fight_scene, go to IDLE. winner stays held until the next LOAD.
- Leaving the fight scene mid-fight: scene_state ≠ fight_scene in any state other than IDLE sends the block to IDLE on the next edge.
  - Delay counter clears.
  - hp, winner and fight_over hold.
  - No attack_valid pulse is issued.
  - Re-entering the fight scene reloads from LOAD.
- Arithmetic: all values are 8-bit unsigned. Subtraction saturates at 0. There is no wrap-around.

## Timing
- key_C sampled at edge k in P1_SELECT:
  - state = P1_ATTACK after edge k;
  - hp, attack_valid and last_damage update at edge k+1;
  - state = CHECK after edge k+1;
  - next turn state, or DONE, after edge k+2.
- P2: entering P2_WAIT at edge j → P2_ATTACK after edge j+AI_DELAY → hp update at edge j+AI_DELAY+1.
- LOAD lasts exactly 1 cycle. IDLE → LOAD → first turn state takes 2 edges.
- attack_valid is high for exactly 1 cycle per attack.
- reset wins over all other inputs on the same edge.

## Configuration
- FIGHT_CRIT_EN:
  - Defined: at each attack, if the ai counter == 0 in the attack-latch cycle (key_C edge, or P2_WAIT terminal edge), the latched damage is doubled, saturating at 8'hFF.
  - Undefined: damage is always the raw skill value. No extra logic is synthesized.

## Test plan
- Turn order: p1 speed 244 vs p2 speed 194 → turn = 0, P1_SELECT. Swap the speeds → turn = 1. Both 100 → turn = 0.
- Cursor: key_D ×3 → cursor 3 (clamped). key_U ×4 → cursor 1. Pulse U+D together → cursor unchanged.
- P1 attack: p2 hp 60, cursor 3, p1 skill3 = 34, key_C → at k+1 p2_cur_hp = 26, attack_valid 1 for 1 cycle, last_damage 34 (crit disabled).
- Saturation and win: p2 hp 20, p1 skill1 = 31, key_C → p2_cur_hp 0, last_damage 20, winner = 1, fight_over = 1. Then scene_state = 4'b0100 → IDLE with winner held at 1.
- P2 delay (AI_DELAY = 4): p2 attack lands exactly 5 edges after entering P2_WAIT. The skill index matches the ai counter + 1; p1_cur_hp drops accordingly.
- Mid-fight abort: scene_state leaves fight_scene during P2_WAIT → IDLE next edge, no attack_valid pulse. Re-entry → hp reloaded to the base values.
